adder_share_arb: RTL
====================

Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares the single registered 4-bit adder datapath between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block issues one pair at a time to the adder, waits out its one-cycle register latency, then returns the sum tagged with the requester id on a valid/ready response port.
- Sits between the input-pin decode logic and the adder instance in the top-level tile.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand width; the adder returns DATA_W+1 bits, carry in the MSB.
- ID_W, 2, requester id width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand pair valid.
- req_a  input  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand B, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant/accept, at most one bit high.
- add_a  output  DATA_W  registered operand A to the shared adder.
- add_b  output  DATA_W  registered operand B to the shared adder.
- add_go  output  1  adder issue strobe, one cycle wide.
- add_sum  input  DATA_W+1  registered adder result, valid the cycle after add_go.
- rsp_valid  output  1  response valid.
- rsp_id  output  ID_W  id of the requester that owns the response.
- rsp_sum  output  DATA_W+1  captured sum.
- rsp_ready  input  1  response consumer ready.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer rr_ptr = 0.
- Reset mid-operation aborts any in-flight pair; the response is lost and not re-issued.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: winner = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If any request is valid: req_ready[winner] = 1 (combinational, this cycle only); latch req_a/req_b of the winner into add_a/add_b; latch the winner into rsp_id; rr_ptr <= winner+1 mod NUM_REQ; go to ISSUE.
  - If no request is valid: stay in IDLE, req_ready = 0.
- ISSUE: add_go = 1 for exactly this cycle; go to WAIT.
- WAIT: capture add_sum into rsp_sum; go to RESP.
- RESP: rsp_valid = 1. rsp_id and rsp_sum stay stable until the handshake.
  - If rsp_ready: go to IDLE. Arbitration happens in the next cycle, not the same cycle.
- req_ready is asserted only in IDLE. A requester that drops valid before the grant loses nothing.
- Latency: request handshake at cycle T, add_go at T+1, rsp_valid at T+3. Peak throughput is one pair per 4 cycles with rsp_ready held high.
- Sum is full width (DATA_W+1), no truncation; 4'hF + 4'hF = 5'h1E.
- add_a/add_b hold their last value outside ISSUE. add_go is the only adder qualifier.
- Fairness: a requester holding valid is granted within NUM_REQ grants.
- All valid simultaneously after reset: grant order is 0,1,2,3,0,...
- rsp_ready held low stalls the FSM in RESP indefinitely; no new grants during the stall.

Optional Feature:
- Macro: ADDER_ARB_GRANT_CNT_EN.
- Defined: adds input cnt_sel [ID_W] and output cnt_out [8].
  - One 8-bit saturating grant counter per requester; it increments on the IDLE grant and sticks at 8'hFF.
  - cnt_out = counter[cnt_sel], combinational.
  - Counters reset to 0.
- Undefined: the ports and counters are absent and arbitration behaviour is identical.

Decomposition:
- Shared package adder_arb_pkg holds:
  - FSM state enum typedef (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - Default DATA_W/NUM_REQ localparams.
  - SUM_W = DATA_W+1 constant.
- Sub-module rr_pick (request vector + pointer -> one-hot grant + winner index, purely combinational) is natural. It is instanced once in adder_share_arb.

Test Plan:
- Single request, req 2 valid with a=4'h3, b=4'h5 → req_ready=4'b0100 at T; add_go at T+1; rsp_valid at T+3 with rsp_id=2, rsp_sum=5'h08.
- Overflow, req 0 with a=4'hF, b=4'hF → rsp_sum=5'h1E, rsp_id=0.
- All four valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0, one every 4 cycles; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid held; rsp_id/rsp_sum stable; req_ready stays 0; on rsp_ready=1 the next grant comes one cycle after the handshake.
- Reset asserted during WAIT → all outputs 0 asynchronously; after release the first grant goes to req 0 (rr_ptr=0).
- With ADDER_ARB_GRANT_CNT_EN: 300 grants to req 1 → cnt_out=8'hFF for cnt_sel=1, and 0 for other requesters that got no grants.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the round-robin adder-sharing arbiter.
package adder_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ID_W    = 2;
  localparam int SUM_W       = DEF_DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // (a + b) mod n for a, b already in [0, n)
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Produces a one-hot grant and the winner index.
module rr_pick
  import adder_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = DEF_ID_W
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;

  // Scan from the pointer; the first hit wins and masks the rest
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'(wrap_add(int'(ptr_i), k, N));
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sequencer sharing one registered adder among NUM_REQ
// requesters: IDLE grants and latches operands, ISSUE strobes the adder,
// WAIT captures the sum, RESP holds the tagged result until accepted.
// Optional: ADDER_ARB_GRANT_CNT_EN adds per-requester saturating grant
// counters readable through cnt_sel/cnt_out.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  output logic                      add_go,
  input  logic [DATA_W:0]           add_sum,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_sum,
  input  logic                      rsp_ready
`ifdef ADDER_ARB_GRANT_CNT_EN
  ,
  input  logic [ID_W-1:0]           cnt_sel,
  output logic [7:0]                cnt_out
`endif
);

  arb_state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] add_a_q, add_b_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [DATA_W:0] rsp_sum_q;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    win_idx;
  logic               any_vld;
  logic               grant;

  logic [NUM_REQ-1:0][DATA_W-1:0] a_vec, b_vec;
  assign a_vec = req_a;
  assign b_vec = req_b;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_oh),
    .idx_o   (win_idx),
    .any_o   (any_vld)
  );

  // State and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state, grant and strobes; grants only from IDLE
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    add_go    = 1'b0;
    rsp_valid = 1'b0;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          grant    = 1'b1;
          // keep outputs quiet while reset is held
          if (!reset) req_ready = grant_oh;
          rr_ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        add_go  = 1'b1;
        state_d = WAIT;
      end
      WAIT: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/id latch on grant, sum capture in WAIT; held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
    end else begin
      if (grant) begin
        add_a_q  <= a_vec[win_idx];
        add_b_q  <= b_vec[win_idx];
        rsp_id_q <= win_idx;
      end
      if (state_q == WAIT) rsp_sum_q <= add_sum;
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_sum = rsp_sum_q;

`ifdef ADDER_ARB_GRANT_CNT_EN
  logic [NUM_REQ-1:0][7:0] cnt_q;

  // Saturating per-requester grant counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (grant) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant_oh[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
    end
  end

  assign cnt_out = (int'(cnt_sel) < NUM_REQ) ? cnt_q[cnt_sel] : 8'h00;
`endif

endmodule
